// File: rtl/vga_pkg.sv
// Types and timing constants shared by the VGA pixel fetch stage and the timing generator.
package vga_pkg;

  localparam int unsigned HFP    = 40;
  localparam int unsigned HPULSE = 128;
  localparam int unsigned HBP    = 88;
  localparam int unsigned VFP    = 13;
  localparam int unsigned VPULSE = 3;
  localparam int unsigned VBP    = 29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  function automatic rgb_t word_to_rgb(input logic [23:0] w);
    return rgb_t'(w);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous DEPTH x 24 pixel FIFO with clear; pop on empty and push on full (without pop) are ignored.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  rgb_t                       din,
  output rgb_t                       head_c,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rgb_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count - CW'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count_d;
      empty  <= (count_d == '0);
      full   <= (count_d == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch over a Wishbone-classic read master, one RGB word per pixel_req.
// Optional saturating underflow counter port enabled by VGA_FETCH_UFCNT_EN.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned HDISP         = 800,
  parameter int unsigned VDISP         = 480,
  parameter logic [31:0] FB_BASE       = 32'h0000_0000,
  parameter int unsigned DEPTH         = 16,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        frame_start,
  input  logic        pixel_req,
  output logic [23:0] pixel_rgb,
  output logic        underflow,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
`ifdef VGA_FETCH_UFCNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int unsigned TOTAL = HDISP * VDISP;
  localparam int unsigned FW    = $clog2(TOTAL + 1);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_d;
  logic          stb_d;
  logic [31:0]   adr_d;
  logic [FW-1:0] fetched;
  logic [FW-1:0] fetched_d;

  logic          fifo_push;
  logic          fifo_clear;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop_eff;
  logic          near_full;
  logic [CW-1:0] fifo_count;
  rgb_t          fifo_head;
  logic          unused_dat;

  assign unused_dat = ^wb_dat_i[31:24];
  assign pop_eff    = pixel_req && !fifo_empty;
  // This push would leave the FIFO full, so the bus must pause after it.
  assign near_full  = (fifo_count == CW'(DEPTH - 1)) && !pop_eff;

  pixel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .pixel_clk(pixel_clk),
    .pixel_rst(pixel_rst),
    .push     (fifo_push),
    .pop      (pixel_req),
    .clear    (fifo_clear),
    .din      (word_to_rgb(wb_dat_i[23:0])),
    .head_c   (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Next-state and bus control.
  always_comb begin
    state_d    = state;
    stb_d      = wb_stb;
    adr_d      = wb_adr;
    fetched_d  = fetched;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;

    case (state)
      FLUSH: begin
        fifo_clear = 1'b1;
        adr_d      = FB_BASE;
        fetched_d  = '0;
        if (wb_stb) begin
          if (wb_ack) begin
            stb_d = 1'b0;
          end
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (wb_stb) begin
          if (wb_ack) begin
            fifo_push = 1'b1;
            adr_d     = wb_adr + 32'd4;
            fetched_d = fetched + FW'(1);
            stb_d     = (fetched_d != FW'(TOTAL)) && !near_full;
            if (fetched_d == FW'(TOTAL)) begin
              state_d = DONE;
            end
          end
        end else if (fetched == FW'(TOTAL)) begin
          state_d = DONE;
        end else if (!fifo_full) begin
          stb_d = 1'b1;
        end
      end
      DONE: begin
        stb_d = 1'b0;
      end
      default: begin
        state_d = FLUSH;
      end
    endcase

    // A new frame overrides everything; a same-cycle ack ends the cycle but its data is dropped.
    if (frame_start) begin
      state_d    = FLUSH;
      fifo_push  = 1'b0;
      fifo_clear = 1'b1;
      adr_d      = FB_BASE;
      fetched_d  = '0;
      stb_d      = wb_stb && !wb_ack;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state   <= FLUSH;
      wb_cyc  <= 1'b0;
      wb_stb  <= 1'b0;
      wb_adr  <= FB_BASE;
      fetched <= '0;
    end else begin
      state   <= state_d;
      wb_cyc  <= stb_d;
      wb_stb  <= stb_d;
      wb_adr  <= adr_d;
      fetched <= fetched_d;
    end
  end

  // Pixel delivery: head on a hit, magenta and a sticky flag on an empty FIFO.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      pixel_rgb <= 24'h0;
      underflow <= 1'b0;
    end else begin
      if (pixel_req) begin
        if (fifo_empty) begin
          pixel_rgb <= UNDERFLOW_RGB;
          underflow <= 1'b1;
        end else begin
          pixel_rgb <= fifo_head;
        end
      end
      if (frame_start) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef VGA_FETCH_UFCNT_EN
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      underflow_cnt <= 16'h0;
    end else if (pixel_req && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized scoreboard bench for vga_pixel_fetch on a tiny 4x2 frame with a 4-entry FIFO.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  localparam int unsigned HDISP   = 4;
  localparam int unsigned VDISP   = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TOTAL   = HDISP * VDISP;
  localparam logic [31:0] FB_BASE = 32'h0000_0000;
  localparam logic [23:0] UF_RGB  = 24'hFF00FF;

  typedef struct packed {
    logic [23:0] rgb;
    logic        uf;
  } exp_t;

  logic        pixel_clk   = 1'b0;
  logic        pixel_rst   = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_req   = 1'b0;
  logic        wb_ack      = 1'b0;
  logic [31:0] wb_dat_i    = 32'h0;
  logic [23:0] pixel_rgb;
  logic        underflow;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_adr;
`ifdef VGA_FETCH_UFCNT_EN
  logic [15:0] underflow_cnt;
  int          m_ufcnt;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] mem [64];
  int          lat     = 0;
  int          lat_cnt = 0;

  // Reference model: the frame is a list of words; acked words queue up, requests take the oldest.
  logic [23:0] m_q [$];
  logic [31:0] m_adr;
  int          m_fetched;
  bit          m_discard;
  bit          m_uf;
  exp_t        sb [$];
  logic        req_q;

  always #5 pixel_clk = ~pixel_clk;

  vga_pixel_fetch #(
    .HDISP        (HDISP),
    .VDISP        (VDISP),
    .FB_BASE      (FB_BASE),
    .DEPTH        (DEPTH),
    .UNDERFLOW_RGB(UF_RGB)
  ) u_dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .frame_start(frame_start),
    .pixel_req  (pixel_req),
    .pixel_rgb  (pixel_rgb),
    .underflow  (underflow),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_adr     (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_ack     (wb_ack)
`ifdef VGA_FETCH_UFCNT_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_adr     = FB_BASE;
    m_fetched = 0;
    m_discard = 1'b0;
    m_uf      = 1'b0;
`ifdef VGA_FETCH_UFCNT_EN
    m_ufcnt   = 0;
`endif
  endtask

  // Called at the negedge: predicts what the coming posedge does with the inputs now applied.
  task automatic model_update();
    exp_t e;
    if (m_fetched == int'(TOTAL) && !m_discard) begin
      check("stb_after_frame", 32'(wb_stb), 32'h0);
    end
    e = '0;
    if (pixel_req) begin
      if (m_q.size() == 0) begin
        e.rgb = UF_RGB;
        m_uf  = 1'b1;
`ifdef VGA_FETCH_UFCNT_EN
        if (m_ufcnt < 65535) m_ufcnt++;
`endif
      end else begin
        e.rgb = m_q.pop_front();
      end
    end
    if (wb_ack && wb_stb) begin
      if (frame_start || m_discard) begin
        m_discard = 1'b0;
      end else begin
        check("wb_adr", wb_adr, m_adr);
        check("wb_cyc_at_ack", 32'(wb_cyc), 32'h1);
        check("fifo_room", 32'(m_q.size() < int'(DEPTH)), 32'h1);
        m_q.push_back(mem[m_adr[7:2]]);
        m_adr     = m_adr + 32'd4;
        m_fetched = m_fetched + 1;
      end
    end
    if (frame_start) begin
      m_q.delete();
      m_adr     = FB_BASE;
      m_fetched = 0;
      m_discard = wb_stb && !wb_ack;
      m_uf      = 1'b0;
    end
    if (pixel_req) begin
      e.uf = m_uf;
      sb.push_back(e);
    end
  endtask

  // One cycle: slave responds, stimulus applied, then the model predicts the next edge.
  task automatic step(input bit req, input bit fs);
    @(posedge pixel_clk);
    #1;
    if (wb_stb) begin
      if (lat_cnt >= lat) begin
        wb_ack   = 1'b1;
        wb_dat_i = {8'($urandom), mem[wb_adr[7:2]]};
        lat_cnt  = 0;
      end else begin
        wb_ack   = 1'b0;
        wb_dat_i = $urandom;
        lat_cnt++;
      end
    end else begin
      wb_ack  = 1'b0;
      lat_cnt = 0;
    end
    pixel_req   = req;
    frame_start = fs;
    @(negedge pixel_clk);
    model_update();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  always @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) req_q <= 1'b0;
    else           req_q <= pixel_req;
  end

  // Monitor: pixel_rgb is valid the cycle after each request.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixel_clk);
      if (req_q) begin
        if (sb.size() == 0) begin
          timeout_fail("sb_empty");
        end else begin
          e = sb.pop_front();
          check("pixel_rgb", 32'(pixel_rgb), 32'(e.rgb));
          check("underflow", 32'(underflow), 32'(e.uf));
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    model_reset();

    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_wb_cyc", 32'(wb_cyc), 32'h0);
    check("rst_wb_stb", 32'(wb_stb), 32'h0);
    check("rst_wb_adr", wb_adr, FB_BASE);
    check("rst_pixel_rgb", 32'(pixel_rgb), 32'h0);
    check("rst_underflow", 32'(underflow), 32'h0);
    check("rst_state", 32'(u_dut.state), 32'(FLUSH));
    @(posedge pixel_clk);
    #3 pixel_rst = 1'b0;

    // Zero-wait slave, spaced requests: whole frame delivered in order.
    lat = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      idle(3);
      step(1'b1, 1'b0);
    end
    idle(4);
    check("a_stb_done", 32'(wb_stb), 32'h0);
    check("a_state_done", 32'(u_dut.state), 32'(DONE));
    check("a_underflow", 32'(underflow), 32'h0);

    // Slow slave: requests outrun the prefetch.
    lat = 5;
    step(1'b0, 1'b1);
    n = 0;
    while (m_q.size() < 2 && n < 200) begin step(1'b0, 1'b0); n++; end
    if (n >= 200) timeout_fail("b_prefetch");
    repeat (6) step(1'b1, 1'b0);
    idle(3);
    check("b_underflow_sticky", 32'(underflow), 32'h1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("b_underflow_cleared", 32'(underflow), 32'h0);

    // frame_start while a read is outstanding.
    lat = 3;
    n = 0;
    while (!(wb_stb && lat_cnt == 1) && n < 200) begin step(1'b0, 1'b0); n++; end
    if (n >= 200) timeout_fail("c_wait_stb");
    step(1'b0, 1'b1);
    idle(30);
    repeat (10) step(1'b1, 1'b0);
    idle(40);
    check("c_state_done", 32'(u_dut.state), 32'(DONE));

    // Randomized frames, latencies and request patterns.
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(0, 3);
      step(1'b0, 1'b1);
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
      end
    end
    for (int c = 0; c < 40; c++) step($urandom_range(0, 1) == 0, 1'b0);

    // Asynchronous reset in the middle of a bus cycle.
    lat = 2;
    step(1'b0, 1'b1);
    n = 0;
    while (!wb_stb && n < 50) begin step(1'b0, 1'b0); n++; end
    if (n >= 50) timeout_fail("e_wait_stb");
    @(posedge pixel_clk);
    #3 pixel_rst = 1'b1;
    #1;
    check("e_rst_wb_cyc", 32'(wb_cyc), 32'h0);
    check("e_rst_wb_stb", 32'(wb_stb), 32'h0);
    check("e_rst_pixel_rgb", 32'(pixel_rgb), 32'h0);
    wb_ack = 1'b0;
    lat_cnt = 0;
    model_reset();
    @(posedge pixel_clk);
    #3 pixel_rst = 1'b0;
    idle(20);
    for (int c = 0; c < 30; c++) step($urandom_range(0, 1) == 0, 1'b0);

`ifdef VGA_FETCH_UFCNT_EN
    // Long run of empty-FIFO requests to saturate the counter.
    lat = 0;
    for (int i = 0; i < 70000; i++) begin
      if (i == 35000) begin
        step(1'b0, 1'b0);
        check("f_cnt_mid", 32'(underflow_cnt), 32'(m_ufcnt));
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("f_cnt_kept", 32'(underflow_cnt), 32'(m_ufcnt));
        check("f_uf_cleared", 32'(underflow), 32'h0);
      end else begin
        step(1'b1, 1'b0);
      end
    end
    idle(2);
    check("f_cnt_model", 32'(underflow_cnt), 32'(m_ufcnt));
    check("f_cnt_sat", 32'(underflow_cnt), 32'h0000_FFFF);
`endif

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Upstream stage of the VGA timing generator, in the pixel_clk domain.
- Reads a linear 24-bit framebuffer over a Wishbone-classic read master and prefetches pixels into a small FIFO.
- Delivers one RGB word per pixel_req strobe, so the timing generator drives RGB from memory instead of its test pattern.
- Restarts at framebuffer base on every frame_start; bad frames are flagged, never stalled.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- FB_BASE, 32'h0000_0000, byte address of pixel (0,0)
- DEPTH, 16, FIFO entries (power of two, >=4)
- UNDERFLOW_RGB, 24'hFF00FF, colour emitted when FIFO is empty on request

Ports:
- pixel_clk  in  1  clock
- pixel_rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse, first cycle of vertical blanking
- pixel_req  in  1  pop one pixel (timing generator's next-cycle BLANK)
- pixel_rgb  out  24  pixel data, valid the cycle after pixel_req
- underflow  out  1  sticky: a request hit an empty FIFO this frame
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_adr  out  32  byte address, word aligned
- wb_dat_i  in  32  read data, RGB in bits [23:0]
- wb_ack  in  1  Wishbone acknowledge
- underflow_cnt  out  16  only with VGA_FETCH_UFCNT_EN

Behaviour:
- Reset (async assert, sync release): FSM=FLUSH, wb_cyc=wb_stb=0, wb_adr=FB_BASE, pixel_rgb=0, underflow=0, FIFO empty, fetched count=0.
- FSM states:
  - FLUSH: wb_cyc/stb held until a pending ack arrives; the ack's data is discarded. FIFO is cleared, wb_adr=FB_BASE, fetched=0. Exit to FETCH the cycle after there are no pending transactions.
  - FETCH: issue reads while fetched < HDISP*VDISP and fifo_count < DEPTH.
  - DONE: entered when fetched == HDISP*VDISP; stays idle until frame_start.
- frame_start in any state: go to FLUSH and clear underflow. It has priority over a same-cycle ack; that ack's data is dropped.
- Bus transaction:
  - Classic, single outstanding: wb_cyc=wb_stb=1 with wb_adr stable until wb_ack.
  - On ack: push wb_dat_i[23:0], wb_adr += 4, fetched += 1.
  - stb deasserts the cycle after ack if the FIFO would then be full or the frame is complete. Otherwise it stays high for back-to-back reads.
  - An ack only arrives with stb high; a push never overflows because stb requires fifo_count < DEPTH.
- Pixel side:
  - pixel_req with FIFO non-empty: pop, pixel_rgb <= head on the next edge.
  - pixel_req with FIFO empty: pixel_rgb <= UNDERFLOW_RGB, underflow <= 1.
  - No pixel_req: pixel_rgb holds.
- Push and pop in the same cycle: count unchanged, both take effect. Pop on empty with a same-cycle push delivers UNDERFLOW_RGB; the pushed word stays queued.
- Widths: fetched is $clog2(HDISP*VDISP+1) bits; fifo_count is $clog2(DEPTH+1) bits; wb_adr wraps modulo 2^32.
- Reset mid-transaction: the bus drops immediately; the slave must tolerate an abandoned cycle.

Optional Feature:
- VGA_FETCH_UFCNT_EN defined:
  - underflow_cnt is a 16-bit saturating count of empty-FIFO requests since reset.
  - Not cleared by frame_start; reset value 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package vga_pkg:
  - rgb_t (24-bit packed struct r,g,b)
  - fetch_state_t enum {FLUSH, FETCH, DONE}
  - timing constants HFP/HPULSE/HBP/VFP/VPULSE/VBP, shared with the timing generator
- Sub-module pixel_fifo: synchronous FIFO, DEPTH x 24.
  - Ports: push, pop, clear, data in, head out, count, empty, full.
  - Async reset.

Test Plan:
- HDISP=4, VDISP=2, DEPTH=4, zero-wait slave, frame_start then 8 spaced pixel_req -> wb_adr sequence 0x0,0x4,...,0x1C; at most 4 reads before the first pop; pixel_rgb equals memory words in order; FSM ends in DONE; underflow=0.
- Slave with 5-cycle ack latency, pixel_req every cycle after the first 2 prefetched words -> third request returns 24'hFF00FF; underflow=1 until the next frame_start.
- frame_start asserted while stb high and ack pending, ack 2 cycles later -> acked data not pushed, FIFO empty, next read at FB_BASE.
- FIFO full (4 entries) with simultaneous pop and ack -> count stays 4, head advances, no data loss, wb_adr increments by 4.
- pixel_rst asserted mid-transaction (async, between edges) -> wb_cyc/wb_stb/pixel_rgb go to 0 without a clock edge; after release, reads start from FB_BASE.
- With VGA_FETCH_UFCNT_EN: 70000 empty-FIFO requests across frames -> underflow_cnt saturates at 16'hFFFF; frame_start clears underflow but not the count.
